// File: rtl/btn_evt_pkg.sv
// Shared types and helpers for the button event controller.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EV_SHORT  = 2'd0,
    EV_LONG   = 2'd1,
    EV_REPEAT = 2'd2
  } ev_kind_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_t;

  // Clock cycles per millisecond tick.
  function automatic int ms_div(input int clk_freq);
    return clk_freq / 1000;
  endfunction

endpackage

// File: rtl/btn_evt_fsm.sv
// One button's press classifier: SHORT on quick release, LONG after LONG_MS, then REPEAT every REPEAT_MS.
module btn_evt_fsm
  import btn_evt_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic     clk,
  input  logic     reset_n,
  input  logic     enable,
  input  logic     tick,
  input  logic     btn,
  output logic     emit,
  output ev_kind_t kind
);

  // Counter is shared by both hold phases, so size it for the longer one.
  localparam int TOP = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int CW  = $clog2(TOP + 1);

  btn_state_t    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    emit     = 1'b0;
    kind     = EV_SHORT;
    if (!enable) begin
      state_nx = IDLE;
      cnt_nx   = '0;
    end else begin
      case (state)
        IDLE: if (btn) begin
          state_nx = PRESSED;
          cnt_nx   = '0;
        end
        PRESSED: begin
          // Release wins over a coincident tick.
          if (!btn) begin
            emit     = 1'b1;
            kind     = EV_SHORT;
            state_nx = IDLE;
          end else if (tick) begin
            if (cnt == CW'(LONG_MS - 1)) begin
              emit     = 1'b1;
              kind     = EV_LONG;
              state_nx = HELD;
              cnt_nx   = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        HELD: begin
          if (!btn) begin
            state_nx = IDLE;
          end else if (tick) begin
            if (cnt == CW'(REPEAT_MS - 1)) begin
              emit   = 1'b1;
              kind   = EV_REPEAT;
              cnt_nx = '0;
            end else begin
              cnt_nx = cnt + CW'(1);
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// N-button event controller: ms prescaler, per-button FSMs, pending slots and a round-robin
// arbiter feeding one valid/ready event port.
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int N_BTN     = 4,
  parameter int CLK_FREQ  = 25_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  localparam int BW       = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [N_BTN-1:0] btn,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [BW-1:0]    ev_btn,
  output logic [1:0]       ev_kind,
  output logic             overrun
);

  localparam int DIV = ms_div(CLK_FREQ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = enable && (pre_cnt == PW'(DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)              pre_cnt <= '0;
    else if (!enable || tick)  pre_cnt <= '0;
    else                       pre_cnt <= pre_cnt + PW'(1);
  end

  logic [N_BTN-1:0]      emit;
  logic [N_BTN-1:0][1:0] kind;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_evt_fsm #(
      .LONG_MS   (LONG_MS),
      .REPEAT_MS (REPEAT_MS)
    ) u_fsm (
      .clk     (clk),
      .reset_n (reset_n),
      .enable  (enable),
      .tick    (tick),
      .btn     (btn[i]),
      .emit    (emit[i]),
      .kind    (kind[i])
    );
  end

  logic [N_BTN-1:0]      pend;
  logic [N_BTN-1:0][1:0] pend_kind;
  logic [BW-1:0]         rr_ptr;
  logic                  load, found;
  logic [BW-1:0]         sel;
  logic [N_BTN-1:0]      grant;
  int                    idx;

  assign load = !ev_valid || ev_ready;

  // Search starts one past the last grant and wraps.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = 0;
    grant = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      idx = (int'(rr_ptr) + k) % N_BTN;
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = BW'(idx);
      end
    end
    if (load && found) grant[sel] = 1'b1;
  end

  // A slot being drained this cycle can take a new event without dropping it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend      <= '0;
      pend_kind <= '0;
      ev_valid  <= 1'b0;
      ev_btn    <= '0;
      ev_kind   <= '0;
      rr_ptr    <= '0;
      overrun   <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) begin
        if (emit[i] && (!pend[i] || grant[i])) begin
          pend[i]      <= 1'b1;
          pend_kind[i] <= kind[i];
        end else if (grant[i]) begin
          pend[i] <= 1'b0;
        end
      end
      overrun <= |(emit & pend & ~grant);
      if (load) begin
        ev_valid <= found;
        if (found) begin
          ev_btn  <= sel;
          ev_kind <= pend_kind[sel];
          rr_ptr  <= sel;
        end
      end
    end
  end

endmodule
